ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the keyboard mode/test-selection logic in the board-test design, clocked from clk7.
- Synchronises and deglitches the raw keyboard clock and data pins.
- Deframes 11-bit device-to-host frames and checks odd parity and the stop bit.
- Folds E0/F0 prefix bytes into flags, so downstream logic receives one clean scancode event per key make or break.

Parameters:
CLKFREQ_KHZ, 7000, system clock frequency in kHz.
TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside a frame before the frame is abandoned.
FILTER_LEN, 4, number of consecutive identical samples required before the filtered PS/2 clock level changes (range 2..15).

Ports:
clk  input  1  system clock (clk7 domain).
rst_n  input  1  reset: synchronous, active-low.
clkps2  input  1  raw PS/2 keyboard clock pin, asynchronous.
dataps2  input  1  raw PS/2 keyboard data pin, asynchronous.
rx_byte  output  8  last correctly received raw byte.
rx_valid  output  1  one-cycle pulse: rx_byte updated.
scancode  output  8  decoded scancode (prefixes removed).
extended  output  1  scancode was preceded by E0.
released  output  1  scancode was preceded by F0 (break code).
scan_valid  output  1  one-cycle pulse: scancode/extended/released valid.
frame_err  output  1  one-cycle pulse: parity error, bad stop bit, or timeout.
busy  output  1  high while a frame is in progress (FSM not IDLE).

Behaviour:
Reset
- On rst_n=0 at a clk edge, all outputs go to 0.
- FSM goes to IDLE; prefix flags clear; timeout counter clears.
- Synchroniser and filter state load 1 (idle bus level).
- Reset wins over everything, including mid-frame activity.

Input conditioning
- Two-flop synchroniser on each pin.
- Filtered clock changes only after FILTER_LEN consecutive identical synchronised samples that differ from the current filtered level.
- Sampled data is the synchronised dataps2 at the filtered-clock falling-edge cycle (fall event).
- Pulses shorter than FILTER_LEN cycles are ignored.
- Fall event occurs exactly FILTER_LEN+2 cycles after a clean raw clkps2 falling edge.

Frame FSM (all transitions on fall events only, except timeout)
- IDLE: data=0 moves to DATA with bit counter=0. data=1 stays in IDLE, no error.
- DATA: shift data into the byte, LSB first. After the 8th bit, move to PARITY.
- PARITY: capture the parity bit; move to STOP.
- STOP: move to IDLE.
  - If stop=1 and (XOR of 8 data bits XOR parity)=1, the byte is accepted.
  - Otherwise, pulse frame_err and clear both prefix flags.
- Timeout: a 16-bit counter increments every cycle outside IDLE and clears on every fall event.
  - Limit = CLKFREQ_KHZ*TIMEOUT_US/1000 (14000 at defaults).
  - On reaching the limit: go to IDLE, pulse frame_err, clear prefix flags.
  - A fall event in the same cycle takes priority over the timeout.
- busy = (state != IDLE).

Byte acceptance (cycle after the STOP fall event)
- rx_byte is updated and rx_valid pulses for 1 cycle.
- rx_valid occurs FILTER_LEN+3 cycles after the raw stop-bit falling edge.
- 0xE0: set the extended flag; no scan_valid.
- 0xF0: set the released flag; no scan_valid.
- Any other byte, including E1 and AA:
  - scancode = byte; extended and released take the flag values.
  - scan_valid pulses in the same cycle as rx_valid.
  - Both flags clear on the next cycle.
- The scancode, extended and released outputs hold their values until the next scan_valid.
- Repeated prefixes (E0 F0) accumulate.

Test Plan:
- Make code: frame for 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> rx_valid 1 pulse with rx_byte=0x1C; scan_valid with scancode=0x1C, extended=0, released=0; frame_err never asserted.
- Break code: bytes F0,1C -> two rx_valid pulses; exactly one scan_valid, with scancode=0x1C, released=1, extended=0.
- Extended break: E0,F0,75 -> one scan_valid with scancode=0x75, extended=1, released=1; a following 0x1C gives extended=0, released=0.
- Parity error: 0x1C sent with parity=1 -> frame_err 1 pulse; no rx_valid or scan_valid; next good 0x29 decodes normally. Bad stop bit (0) -> same response.
- Timeout / glitch: stop clocking after 5 data bits -> frame_err after 14000 cycles, busy returns to 0. A 2-cycle low pulse on clkps2 while idle -> no fall event, busy stays 0.
- Reset mid-frame: assert rst_n=0 for 1 cycle after 4 bits -> all outputs 0, busy=0; the remainder of that frame is discarded without scan_valid; the next full frame 0x5A decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the keyboard pins, deframes
// 11-bit frames, and folds E0/F0 prefixes into flags on a single scancode event.
module ps2_keyboard_rx #(
  parameter int CLKFREQ_KHZ = 7000,
  parameter int TIMEOUT_US  = 2000,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int          TO_LIMIT  = CLKFREQ_KHZ * TIMEOUT_US / 1000;
  localparam logic [15:0] TO_LAST   = 16'(TO_LIMIT - 1);
  localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [7:0] b, input logic p, input logic s);
    return s & ((^b) ^ p);
  endfunction

  logic       clk_p0, clk_p1, dat_p0, dat_p1;
  logic       clk_filt;
  logic [3:0] filt_cnt;
  logic       fall_p2;

  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par;
  logic [15:0] to_cnt;
  logic        ext_f, rel_f;

  // Stage p0/p1: synchronisers; p2: filtered clock and its falling-edge event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_p0   <= 1'b1;
      clk_p1   <= 1'b1;
      dat_p0   <= 1'b1;
      dat_p1   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= 4'd0;
      fall_p2  <= 1'b0;
    end else begin
      clk_p0  <= clkps2;
      clk_p1  <= clk_p0;
      dat_p0  <= dataps2;
      dat_p1  <= dat_p0;
      fall_p2 <= 1'b0;
      if (clk_p1 != clk_filt) begin
        if (filt_cnt == FILT_LAST) begin
          clk_filt <= clk_p1;
          filt_cnt <= 4'd0;
          fall_p2  <= clk_filt;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= 4'd0;
      end
    end
  end

  // Stage p3: frame FSM, prefix folding and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      par        <= 1'b0;
      to_cnt     <= 16'd0;
      ext_f      <= 1'b0;
      rel_f      <= 1'b0;
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      scancode   <= 8'd0;
      extended   <= 1'b0;
      released   <= 1'b0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= 16'd0;
        if (fall_p2 && !dat_p1) begin
          state   <= DATA;
          bit_cnt <= 3'd0;
        end
      end else if (fall_p2) begin
        to_cnt <= 16'd0;
        case (state)
          DATA: begin
            shift   <= {dat_p1, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_p1;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (frame_ok(shift, par, dat_p1)) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
              if (shift == 8'hE0) begin
                ext_f <= 1'b1;
              end else if (shift == 8'hF0) begin
                rel_f <= 1'b1;
              end else begin
                scancode   <= shift;
                extended   <= ext_f;
                released   <= rel_f;
                scan_valid <= 1'b1;
                ext_f      <= 1'b0;
                rel_f      <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_f     <= 1'b0;
              rel_f     <= 1'b0;
            end
          end
        endcase
      end else if (to_cnt == TO_LAST) begin
        state     <= IDLE;
        to_cnt    <= 16'd0;
        frame_err <= 1'b1;
        ext_f     <= 1'b0;
        rel_f     <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
